// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from combinational imem into a
// small prefetch FIFO, handles redirect/halt. Optional perf counters under FETCH_PERF_EN.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
`ifdef FETCH_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    input  logic        perf_clear,
`endif
    output logic        halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_pc;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_data [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_last_data;
    logic [31:0]   r_last_pc;

    logic w_valid;
    logic w_pop;
    logic w_flush;
    logic w_full;
    logic w_push;

    // Handshake: a head entry transfers on any posedge where instr_valid && instr_ready;
    // instr_valid never depends on instr_ready, and a redirect voids a coinciding transfer.
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && instr_ready;
    assign w_flush = redirect && (r_state != ST_IDLE);
    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = (r_state == ST_RUN) && !w_flush && !halt_req && (!w_full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN:  if (halt_req)  w_state_nxt = ST_HALT;
            ST_HALT: if (!halt_req) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush)
                r_pc <= redirect_pc;
            else if (w_push)
                r_pc <= r_pc + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_pc;
        end
    end

    // Snapshot of the displayed head so the outputs hold it once the FIFO empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_data <= '0;
            r_last_pc   <= '0;
        end else if (w_valid) begin
            r_last_data <= r_mem_data[r_rd_ptr];
            r_last_pc   <= r_mem_pc[r_rd_ptr];
        end
    end

    assign imem_addr   = r_pc;
    assign instr_valid = w_valid;
    assign instr_out   = w_valid ? r_mem_data[r_rd_ptr] : r_last_data;
    assign instr_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : r_last_pc;
    assign halted      = (r_state == ST_HALT);

`ifdef FETCH_PERF_EN
    logic        w_stall;
    logic        w_flush_hit;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    assign w_stall     = (r_state == ST_RUN) && !w_flush && !halt_req && w_full && !w_pop;
    assign w_flush_hit = w_flush && w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else if (perf_clear) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush_hit && (r_flush_count != 32'hFFFF_FFFF))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the combinational instruction memory.
- Owns the program counter and drives the word address into instruction memory each cycle.
- Captures the returned word into a small prefetch FIFO and hands instructions to decode over a valid/ready handshake.
- Handles branch/jump redirect (flush plus PC reload) and a halt request from the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Word index; instruction memory uses pc[7:0] as word address.
- DEPTH, 2, prefetch FIFO entries. Power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_addr  output  32  word address to instruction memory; always equals internal pc.
- imem_rdata  input  32  combinational instruction word for imem_addr.
- instr_out  output  32  instruction at FIFO head.
- instr_pc  output  32  PC of instr_out.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  decode accepts head this cycle.
- redirect  input  1  one-cycle pulse: flush and refetch from redirect_pc.
- redirect_pc  input  32  target word address, sampled when redirect=1.
- halt_req  input  1  level: stop fetching while high.
- halted  output  1  state is HALT.

Behaviour:
- Reset (async assert, rst_n=0):
  - pc=RESET_PC; FIFO empty; state=IDLE.
  - instr_valid=0, instr_out=0, instr_pc=0, halted=0.
- States IDLE, RUN, HALT. Transitions evaluated at posedge:
  - IDLE -> RUN unconditionally after one cycle (memory settle slot; no fetch in IDLE).
  - RUN -> HALT when halt_req=1.
  - HALT -> RUN when halt_req=0.
  - halted=1 exactly while state=HALT.
- Pop: instr_valid && instr_ready at posedge removes the head entry.
- Push (RUN only, redirect=0):
  - Occurs when count<DEPTH, or count==DEPTH with a pop in the same cycle.
  - Writes {pc, imem_rdata} at the tail; pc<=pc+1.
  - Push and pop in the same cycle leave count unchanged.
- Push is also suppressed in the cycle where RUN->HALT is taken (halt_req=1 sampled in RUN): no new fetch once halt is requested.
- Latency: a word at imem_addr in cycle N appears on instr_out no earlier than cycle N+1 (registered FIFO). Back-to-back throughput is 1 instr/cycle with DEPTH>=2 and instr_ready held high.
- Redirect (highest priority, any state except IDLE):
  - FIFO flushed, so instr_valid=0 the next cycle.
  - pc<=redirect_pc. No push that cycle.
  - A pop coinciding with redirect is void; the head is discarded by the flush.
  - State unchanged: redirect in HALT updates pc and flushes but stays HALT.
- HALT: no pushes and pc frozen. The FIFO keeps draining to decode normally.
- Redirect in IDLE: ignored (IDLE lasts one cycle after reset).
- PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFF -> 0. Memory aliasing via pc[7:0] is not this block's concern.
- FIFO: circular read/write pointers of log2(DEPTH) bits plus occupancy count 0..DEPTH.
  - Never overflows or underflows; the push condition guarantees this.
- instr_out/instr_pc: hold the last head value when empty; content is don't-care when instr_valid=0.
- Reset mid-operation: immediate return to reset values regardless of state or FIFO contents.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three ports:
  - stall_cycles (output, 32): counts RUN cycles with push blocked by a full FIFO.
  - flush_count (output, 32): counts redirects that discarded at least one valid entry.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
  - perf_clear (input, 1): synchronous clear of both counters; takes priority over increment.
- When undefined: none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- Reset release, instr_ready=1, imem model returns word = 32'hA000_0000 | addr -> instr_valid first high 2 cycles after release, instr_pc=0,1,2,... consecutive, instr_out=32'hA000_0000, 32'hA000_0001, ..., one per cycle.
- instr_ready=0 for 6 cycles, DEPTH=2 -> FIFO fills, pc stops at RESET_PC+2, instr_out holds word 0; on ready=1 delivers 0,1,2 with no gap or duplicate.
- With FIFO holding pc 4,5: pulse redirect with redirect_pc=32'h40 and instr_ready=1 -> next cycle instr_valid=0; the following cycle instr_pc=32'h40; pc 4 and 5 never accepted.
- halt_req=1 for 5 cycles with ready=1 -> halted=1 from the next cycle, FIFO drains, pc constant; halt_req=0 -> fetch resumes at the frozen pc with no skipped address.
- pc forced via redirect to 32'hFFFF_FFFF -> instr_pc sequence FFFF_FFFF, 0000_0000, 0000_0001.
- rst_n asserted mid-stream with FIFO full -> instr_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
- FETCH_PERF_EN: 4 full-stall cycles plus 1 flushing redirect -> stall_cycles=4, flush_count=1; perf_clear -> both 0 the next cycle.
